// File: rtl/mmio_hub_pkg.sv
// -----------------------------------------------------------------------------
// mmio_hub_pkg
// Shared constants for the MMIO peripheral hub: register offsets inside the
// 256-byte window, the default window base, and a helper that expands the low
// two byte strobes into a per-bit write mask for the 16-bit button registers.
// -----------------------------------------------------------------------------
package mmio_hub_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hffff_ff00;

    // Offsets within the window (byte addresses, word aligned)
    localparam logic [7:0] SW_BASE_OFF   = 8'h00;  // SW[i]  at SW_BASE_OFF  + 4*i
    localparam logic [7:0] LED_BASE_OFF  = 8'h40;  // LED[i] at LED_BASE_OFF + 4*i
    localparam logic [7:0] BTN_LEVEL_OFF = 8'h80;
    localparam logic [7:0] BTN_EDGE_OFF  = 8'h84;
    localparam logic [7:0] BTN_IE_OFF    = 8'h88;

    // Bits [7:0] are enabled by strobe 0, bits [15:8] by strobe 1.
    function automatic logic [15:0] byte_mask16(input logic [1:0] strb);
        return {{8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/mmio_hub_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button channel: 2-flop synchroniser, optional debounce counter and
// a rising-edge indication aligned with the debounced level update.
//
// Build option: define MMIO_DEBOUNCE_EN to enable the debounce counter. When
// undefined, the debounced level is the synchroniser output and no counter
// exists.
//
// Ports:
//   clk      in   clock, all state on posedge
//   rst      in   synchronous reset, active-high
//   i_btn    in   raw asynchronous button input, active-high
//   o_level  out  debounced button level (registered)
//   o_rise   out  high in the cycle whose clock edge raises o_level 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_flip;

    // Input has disagreed with the level for DEBOUNCE_CYC consecutive cycles
    // once the counter sits at its last value and still sees a mismatch.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (w_flip) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_flip && !r_level;
`else
    // Same parameter list in both builds; the value has no effect here.
    localparam int unsigned UNUSED_DEBOUNCE_CYC = DEBOUNCE_CYC;

    assign o_level = r_sync2;
    assign o_rise  = r_sync1 && !r_sync2;
`endif

endmodule

// File: rtl/mmio_hub.sv
// -----------------------------------------------------------------------------
// mmio_hub
// Memory-mapped peripheral hub for the data-port MMIO window: synchronised
// switch banks, byte-strobed LED registers, debounced buttons with sticky
// rising-edge flags (write-1-to-clear), interrupt enables and a registered
// level interrupt.
//
// Build option: MMIO_DEBOUNCE_EN enables per-button debounce counters
// (see btn_debounce); otherwise button levels follow the synchronisers.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req, we         one-cycle access request; 1 = write
//   addr            byte address (word aligned)
//   wdata, wstrb    write data and byte enables
//   rdata, rvalid   registered read data and its one-cycle valid pulse
//   switches        raw switch banks, NUM_SW x 8, asynchronous
//   btn             raw buttons, NUM_BTN, asynchronous, active-high
//   led_out         LED register contents, NUM_LED x 8
//   irq             registered interrupt = |(BTN_EDGE & BTN_IE)
// -----------------------------------------------------------------------------
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter int          NUM_SW       = 3,
    parameter int          NUM_LED      = 3,
    parameter int          NUM_BTN      = 5,
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    output logic [31:0]              rdata,
    output logic                     rvalid,
    input  logic [NUM_SW-1:0][7:0]   switches,
    input  logic [NUM_BTN-1:0]       btn,
    output logic [NUM_LED-1:0][7:0]  led_out,
    output logic                     irq
);

    logic                    w_hit;
    logic                    w_rd;
    logic                    w_wr;
    logic [7:0]              w_off;
    logic [15:0]             w_strb_mask;
    logic [NUM_BTN-1:0]      w_wr_mask;
    logic [NUM_BTN-1:0]      w_wr_bits;
    logic [NUM_BTN-1:0]      w_edge_clr;
    logic [NUM_BTN-1:0]      w_level;
    logic [NUM_BTN-1:0]      w_rise;
    logic [31:0]             w_rd_data;
    logic                    w_unused;

    logic [NUM_SW-1:0][7:0]  r_sw_sync1;
    logic [NUM_SW-1:0][7:0]  r_sw_sync2;
    logic [NUM_LED-1:0][7:0] r_led;
    logic [NUM_BTN-1:0]      r_ie;
    logic [NUM_BTN-1:0]      r_edge;
    logic [31:0]             r_rdata;
    logic                    r_rvalid;
    logic                    r_irq;

    // Every read request returns a pulse, hit or not; only hits touch state.
    assign w_hit = req && (addr[31:8] == BASE_ADDR[31:8]);
    assign w_rd  = req && !we;
    assign w_wr  = w_hit && we;
    assign w_off = {addr[7:2], 2'b00};

    assign w_strb_mask = byte_mask16(wstrb[1:0]);
    assign w_wr_mask   = w_strb_mask[NUM_BTN-1:0];
    assign w_wr_bits   = wdata[NUM_BTN-1:0] & w_wr_mask;
    assign w_edge_clr  = (w_wr && (w_off == BTN_EDGE_OFF)) ? w_wr_bits : '0;

    // Bits not consumed for the current parameter set.
    assign w_unused = ^{addr[1:0], wdata, wstrb, w_strb_mask};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn[b]),
            .o_level (w_level[b]),
            .o_rise  (w_rise[b])
        );
    end

    // NOTE: the default assignment first means every path drives w_rd_data,
    // so no latch is inferred when no register matches.
    always_comb begin
        w_rd_data = '0;
        if (w_hit) begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (w_off == SW_BASE_OFF + 8'(4 * i))
                    w_rd_data = {24'h0, r_sw_sync2[i]};
            end
            for (int i = 0; i < NUM_LED; i++) begin
                if (w_off == LED_BASE_OFF + 8'(4 * i))
                    w_rd_data = {24'h0, r_led[i]};
            end
            if (w_off == BTN_LEVEL_OFF) w_rd_data = 32'(w_level);
            if (w_off == BTN_EDGE_OFF)  w_rd_data = 32'(r_edge);
            if (w_off == BTN_IE_OFF)    w_rd_data = 32'(r_ie);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
            r_led      <= '0;
            r_ie       <= '0;
            r_edge     <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sw_sync1 <= switches;
            r_sw_sync2 <= r_sw_sync1;

            for (int i = 0; i < NUM_LED; i++) begin
                if (w_wr && wstrb[0] && (w_off == LED_BASE_OFF + 8'(4 * i)))
                    r_led[i] <= wdata[7:0];
            end

            if (w_wr && (w_off == BTN_IE_OFF))
                r_ie <= (r_ie & ~w_wr_mask) | w_wr_bits;

            // Clear is applied before the set so a rise in the same cycle wins.
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;

            r_irq    <= |(r_edge & r_ie);
            r_rvalid <= w_rd;
            if (w_rd)
                r_rdata <= w_rd_data;
        end
    end

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign led_out = r_led;
    assign irq     = r_irq;

endmodule
